// File: rtl/hispi_frame_tx.sv
// hispi_frame_tx
//   Frames 32-bit AXIS pixel beats (4 px x 8 bit) as 4-lane HiSPi Packetized-SP
//   parallel words (4 x 10 bit). Each line is a sync preamble (SOF/SOL), LINE_WORDS
//   active words, a sync trailer (EOL/EOF), then horizontal blanking. A vertical
//   blanking gap follows the last line. Frames repeat back-to-back while run is high.
//
//   Optional build macro: HISPI_TX_TESTPAT_EN
//     Adds input test_pattern. When it is high at the start of a frame, the frame's
//     active words carry an 8-bit ramp instead of AXIS data and AXIS is never read.
//
// Ports
//   clk              single clock
//   reset_sync       synchronous active-high reset
//   run              level; frames are generated back-to-back while high
//   axis_data[31:0]  pixels, [31:24]=lane3 ... [7:0]=lane0
//   axis_valid       AXIS valid
//   axis_ready       AXIS ready, high exactly in active word slots
//   test_pattern     (HISPI_TX_TESTPAT_EN only) select ramp data for the next frame
//   lane_data[39:0]  registered lane words, [39:30]=lane3 ... [9:0]=lane0
//   frame_active     high from the SOF preamble through the EOF code
//   frame_done       1-cycle pulse coincident with the EOF code word
//   frame_count      frames started, wraps
//   underflow_count  active slots with no input beat, saturates at 255

module hispi_frame_tx #(
   parameter int unsigned LINE_WORDS = 160,
   parameter int unsigned LINES      = 480,
   parameter int unsigned H_BLANK    = 16,
   parameter int unsigned V_BLANK    = 64
) (
   input  logic        clk,
   input  logic        reset_sync,
   input  logic        run,
   input  logic [31:0] axis_data,
   input  logic        axis_valid,
`ifdef HISPI_TX_TESTPAT_EN
   input  logic        test_pattern,
`endif
   output logic        axis_ready,
   output logic [39:0] lane_data,
   output logic        frame_active,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic [7:0]  underflow_count
);

   localparam logic [9:0] CodeBlank = 10'h001;
   localparam logic [9:0] CodeSof   = 10'h180;
   localparam logic [9:0] CodeSol   = 10'h080;
   localparam logic [9:0] CodeEof   = 10'h380;
   localparam logic [9:0] CodeEol   = 10'h280;

   // Terminal counts, pre-sized to the 16-bit counters
   localparam logic [15:0] LastWord   = 16'(LINE_WORDS - 1);
   localparam logic [15:0] LastLine   = 16'(LINES - 1);
   localparam logic [15:0] LastHblank = 16'(H_BLANK - 1);
   localparam logic [15:0] LastVblank = 16'(V_BLANK - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSyncStart,
      StActive,
      StSyncEnd,
      StHblank,
      StVblank
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  phase_q, phase_d;   // position inside a 4-word sync sequence
   logic [15:0] word_q, word_d;     // active word within the line
   logic [15:0] line_q, line_d;     // active line within the frame
   logic [15:0] blank_q, blank_d;   // blanking cycle within H/V blank
   logic [39:0] lane_q, lane_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic [7:0]  fcount_q, fcount_d;
   logic [7:0]  ucount_q, ucount_d;

`ifdef HISPI_TX_TESTPAT_EN
   logic        tp_q, tp_d;         // test pattern selection, held for the frame
   logic [7:0]  ramp_q, ramp_d;
   logic [39:0] ramp_word;
`endif

   logic [39:0] pix_word;
   logic        first_line;
   logic        last_line;
   logic        start_frame;

   // 4-word sync sequence: 3FF, 000, 000, CODE
   function automatic logic [9:0] sync_word(input logic [1:0] ph, input logic [9:0] code);
      logic [9:0] w;
      unique case (ph)
         2'd0:    w = 10'h3FF;
         2'd3:    w = code;
         default: w = 10'h000;
      endcase
      return w;
   endfunction

   // 8-bit pixels widen to 10 bits by appending two zero LSBs, so a pixel
   // never reaches 3FF and cannot be mistaken for a sync lead-in.
   always_comb begin
      pix_word = '0;
      for (int k = 0; k < 4; k++) begin
         pix_word[10*k +: 10] = {axis_data[8*k +: 8], 2'b00};
      end
   end

`ifdef HISPI_TX_TESTPAT_EN
   always_comb begin
      ramp_word = '0;
      for (int k = 0; k < 4; k++) begin
         ramp_word[10*k +: 10] = {ramp_q + 8'(k), 2'b00};
      end
   end
`endif

   assign first_line = (line_q == 16'd0);
   assign last_line  = (line_q == LastLine);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      word_d      = word_q;
      line_d      = line_q;
      blank_d     = blank_q;
      lane_d      = {4{CodeBlank}};
      active_d    = 1'b0;
      done_d      = 1'b0;
      fcount_d    = fcount_q;
      ucount_d    = ucount_q;
      axis_ready  = 1'b0;
      start_frame = 1'b0;
`ifdef HISPI_TX_TESTPAT_EN
      tp_d        = tp_q;
      ramp_d      = ramp_q;
`endif

      unique case (state_q)
         StIdle: begin
            start_frame = run;
         end

         StSyncStart: begin
            active_d = 1'b1;
            lane_d   = {4{sync_word(phase_q, first_line ? CodeSof : CodeSol)}};
            phase_d  = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               // Frame counts the moment its SOF code lands on lane_data
               if (first_line) begin
                  fcount_d = fcount_q + 8'd1;
               end
               state_d = StActive;
               word_d  = 16'd0;
            end
         end

         StActive: begin
            active_d = 1'b1;
`ifdef HISPI_TX_TESTPAT_EN
            axis_ready = ~tp_q;
            if (tp_q) begin
               lane_d = ramp_word;
               ramp_d = ramp_q + 8'd1;
            end else if (axis_valid) begin
               lane_d = pix_word;
            end else begin
               lane_d = '0;
               if (ucount_q != 8'hFF) begin
                  ucount_d = ucount_q + 8'd1;
               end
            end
`else
            axis_ready = 1'b1;
            if (axis_valid) begin
               lane_d = pix_word;
            end else begin
               // Missing beat: the slot is still consumed so line timing never slips
               lane_d = '0;
               if (ucount_q != 8'hFF) begin
                  ucount_d = ucount_q + 8'd1;
               end
            end
`endif
            word_d = word_q + 16'd1;
            if (word_q == LastWord) begin
               state_d = StSyncEnd;
               phase_d = 2'd0;
            end
         end

         StSyncEnd: begin
            active_d = 1'b1;
            lane_d   = {4{sync_word(phase_q, last_line ? CodeEof : CodeEol)}};
            phase_d  = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               done_d  = last_line;
               blank_d = 16'd0;
               state_d = last_line ? StVblank : StHblank;
            end
         end

         StHblank: begin
            active_d = 1'b1;
            blank_d  = blank_q + 16'd1;
            if (blank_q == LastHblank) begin
               state_d = StSyncStart;
               phase_d = 2'd0;
               line_d  = line_q + 16'd1;
            end
         end

         StVblank: begin
            blank_d = blank_q + 16'd1;
            if (blank_q == LastVblank) begin
               // run is only looked at here and in IDLE, so a frame always completes
               if (run) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (start_frame) begin
         state_d = StSyncStart;
         phase_d = 2'd0;
         line_d  = 16'd0;
         word_d  = 16'd0;
`ifdef HISPI_TX_TESTPAT_EN
         tp_d    = test_pattern;
         ramp_d  = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset_sync) begin
         state_q  <= StIdle;
         phase_q  <= 2'd0;
         word_q   <= 16'd0;
         line_q   <= 16'd0;
         blank_q  <= 16'd0;
         lane_q   <= {4{CodeBlank}};
         active_q <= 1'b0;
         done_q   <= 1'b0;
         fcount_q <= 8'd0;
         ucount_q <= 8'd0;
`ifdef HISPI_TX_TESTPAT_EN
         tp_q     <= 1'b0;
         ramp_q   <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         word_q   <= word_d;
         line_q   <= line_d;
         blank_q  <= blank_d;
         lane_q   <= lane_d;
         active_q <= active_d;
         done_q   <= done_d;
         fcount_q <= fcount_d;
         ucount_q <= ucount_d;
`ifdef HISPI_TX_TESTPAT_EN
         tp_q     <= tp_d;
         ramp_q   <= ramp_d;
`endif
      end
   end

   assign lane_data       = lane_q;
   assign frame_active    = active_q;
   assign frame_done      = done_q;
   assign frame_count     = fcount_q;
   assign underflow_count = ucount_q;

endmodule

// File: tb/tb_hispi_frame_tx.sv
// Directed bench for hispi_frame_tx with a small frame geometry
// (4 words/line, 2 lines, 2 H-blank, 3 V-blank => 29-cycle frame).

module tb_hispi_frame_tx;

   localparam int unsigned LW   = 4;
   localparam int unsigned LN   = 2;
   localparam int unsigned HB   = 2;
   localparam int unsigned VB   = 3;
   localparam int unsigned FLEN = LN * (LW + 8) + (LN - 1) * HB + VB;

   localparam logic [9:0] BLANK = 10'h001;
   localparam logic [9:0] SOF   = 10'h180;
   localparam logic [9:0] SOL   = 10'h080;
   localparam logic [9:0] EOF   = 10'h380;
   localparam logic [9:0] EOL   = 10'h280;

   logic        clk = 1'b0;
   logic        reset_sync = 1'b1;
   logic        run = 1'b0;
   logic [31:0] axis_data = 32'h0;
   logic        axis_valid = 1'b1;
   logic        axis_ready;
   logic [39:0] lane_data;
   logic        frame_active;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic [7:0]  underflow_count;
`ifdef HISPI_TX_TESTPAT_EN
   logic        test_pattern = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   int beat_idx  = 0;   // next AXIS beat to present
   int ready_cnt = 0;   // active slots seen since the last reset
   int skip_slot = -1;  // slot in which valid is withheld
   bit no_valid  = 1'b0;

   logic [39:0] exp_lane [FLEN];
   logic        exp_done [FLEN];
   logic        exp_act  [FLEN];

   always #5 clk = ~clk;

   hispi_frame_tx #(
      .LINE_WORDS(LW),
      .LINES     (LN),
      .H_BLANK   (HB),
      .V_BLANK   (VB)
   ) dut (
      .clk            (clk),
      .reset_sync     (reset_sync),
      .run            (run),
      .axis_data      (axis_data),
      .axis_valid     (axis_valid),
`ifdef HISPI_TX_TESTPAT_EN
      .test_pattern   (test_pattern),
`endif
      .axis_ready     (axis_ready),
      .lane_data      (lane_data),
      .frame_active   (frame_active),
      .frame_done     (frame_done),
      .frame_count    (frame_count),
      .underflow_count(underflow_count)
   );

   function automatic logic [31:0] beat_word(input int b);
      logic [7:0] b0;
      b0 = 8'(4 * b);
      return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
   endfunction

   function automatic logic [39:0] rep(input logic [9:0] c);
      return {c, c, c, c};
   endfunction

   function automatic logic [39:0] pix(input logic [31:0] w);
      return {w[31:24], 2'b00, w[23:16], 2'b00, w[15:8], 2'b00, w[7:0], 2'b00};
   endfunction

   function automatic logic [39:0] ramp_word(input int r);
      return {8'(r + 3), 2'b00, 8'(r + 2), 2'b00, 8'(r + 1), 2'b00, 8'(r), 2'b00};
   endfunction

   // Expected lane words for one whole frame, starting with the 3FF of SOF
   function automatic void build_frame(input int first_beat, input bit tp);
      int i;
      int b;
      int r;
      int eof_idx;
      i = 0;
      b = first_beat;
      r = 0;
      eof_idx = 0;
      for (int l = 0; l < int'(LN); l++) begin
         exp_lane[i]     = rep(10'h3FF);
         exp_lane[i + 1] = rep(10'h000);
         exp_lane[i + 2] = rep(10'h000);
         exp_lane[i + 3] = rep(l == 0 ? SOF : SOL);
         i += 4;
         for (int w = 0; w < int'(LW); w++) begin
            if (tp) begin
               exp_lane[i] = ramp_word(r);
               r++;
            end else if (l * int'(LW) + w == skip_slot) begin
               exp_lane[i] = '0;
            end else begin
               exp_lane[i] = pix(beat_word(b));
               b++;
            end
            i++;
         end
         exp_lane[i]     = rep(10'h3FF);
         exp_lane[i + 1] = rep(10'h000);
         exp_lane[i + 2] = rep(10'h000);
         exp_lane[i + 3] = rep(l == int'(LN) - 1 ? EOF : EOL);
         if (l == int'(LN) - 1) eof_idx = i + 3;
         i += 4;
         if (l != int'(LN) - 1) begin
            for (int h = 0; h < int'(HB); h++) begin
               exp_lane[i] = rep(BLANK);
               i++;
            end
         end
      end
      for (int v = 0; v < int'(VB); v++) begin
         exp_lane[i] = rep(BLANK);
         i++;
      end
      for (int j = 0; j < int'(FLEN); j++) begin
         exp_done[j] = (j == eof_idx);
         exp_act[j]  = (j <= eof_idx);
      end
   endfunction

   // One clock: note a handshake in the ending cycle, then after the edge
   // present the next beat and decide valid for the new cycle.
   task automatic tick();
      logic hs;
      hs = axis_ready && axis_valid;
      @(posedge clk);
      #1;
      if (hs === 1'b1) beat_idx++;
      axis_data = beat_word(beat_idx);
      if (axis_ready === 1'b1) begin
         axis_valid = !(no_valid || ready_cnt == skip_slot);
         ready_cnt++;
      end else begin
         axis_valid = !no_valid;
      end
   endtask

   task automatic do_reset();
      reset_sync = 1'b1;
      run        = 1'b0;
      no_valid   = 1'b0;
      skip_slot  = -1;
      axis_valid = 1'b1;
      tick();
      tick();
      reset_sync = 1'b0;
      ready_cnt  = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (lane_data !== rep(BLANK)) begin
         bad++; $display("FAIL reset_lane got=%h want=%h", lane_data, rep(BLANK));
      end
      total++;
      if (axis_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready got=%b want=0", axis_ready);
      end
      total++;
      if (frame_active !== 1'b0) begin
         bad++; $display("FAIL reset_active got=%b want=0", frame_active);
      end
      total++;
      if (frame_done !== 1'b0) begin
         bad++; $display("FAIL reset_done got=%b want=0", frame_done);
      end
      total++;
      if (frame_count !== 8'd0) begin
         bad++; $display("FAIL reset_fcount got=%0d want=0", frame_count);
      end
      total++;
      if (underflow_count !== 8'd0) begin
         bad++; $display("FAIL reset_ucount got=%0d want=0", underflow_count);
      end
   endtask

   task automatic test_single_frame();
      do_reset();
      build_frame(beat_idx, 1'b0);
      run = 1'b1;
      tick();
      run = 1'b0;
      total++;
      if (lane_data !== rep(BLANK)) begin
         bad++; $display("FAIL single_pre got=%h want=%h", lane_data, rep(BLANK));
      end
      for (int i = 0; i < int'(FLEN); i++) begin
         tick();
         total++;
         if (lane_data !== exp_lane[i]) begin
            bad++; $display("FAIL single_lane[%0d] got=%h want=%h", i, lane_data, exp_lane[i]);
         end
         total++;
         if (frame_done !== exp_done[i]) begin
            bad++; $display("FAIL single_done[%0d] got=%b want=%b", i, frame_done, exp_done[i]);
         end
         total++;
         if (frame_active !== exp_act[i]) begin
            bad++; $display("FAIL single_act[%0d] got=%b want=%b", i, frame_active, exp_act[i]);
         end
         if (i == 3) begin
            total++;
            if (frame_count !== 8'd1) begin
               bad++; $display("FAIL single_fcount_sof got=%0d want=1", frame_count);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (lane_data !== rep(BLANK) || frame_active !== 1'b0) begin
            bad++; $display("FAIL single_idle[%0d] got=%h/%b want=%h/0", i, lane_data,
                            frame_active, rep(BLANK));
         end
      end
      total++;
      if (frame_count !== 8'd1) begin
         bad++; $display("FAIL single_fcount got=%0d want=1", frame_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run = 1'b1;
      tick();
      for (int f = 0; f < 2; f++) begin
         build_frame(beat_idx, 1'b0);
         for (int i = 0; i < int'(FLEN); i++) begin
            tick();
            if (f == 1 && i == 6) run = 1'b0;
            total++;
            if (lane_data !== exp_lane[i]) begin
               bad++; $display("FAIL b2b_lane[%0d][%0d] got=%h want=%h", f, i, lane_data,
                               exp_lane[i]);
            end
            total++;
            if (frame_done !== exp_done[i]) begin
               bad++; $display("FAIL b2b_done[%0d][%0d] got=%b want=%b", f, i, frame_done,
                               exp_done[i]);
            end
            if (i == 3) begin
               total++;
               if (frame_count !== 8'(f + 1)) begin
                  bad++; $display("FAIL b2b_fcount[%0d] got=%0d want=%0d", f, frame_count, f + 1);
               end
            end
         end
      end
      tick();
      total++;
      if (lane_data !== rep(BLANK) || frame_active !== 1'b0) begin
         bad++; $display("FAIL b2b_idle got=%h/%b want=%h/0", lane_data, frame_active, rep(BLANK));
      end
   endtask

   task automatic test_underflow();
      do_reset();
      skip_slot = 1;
      build_frame(beat_idx, 1'b0);
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < int'(FLEN); i++) begin
         tick();
         total++;
         if (lane_data !== exp_lane[i]) begin
            bad++; $display("FAIL uflow_lane[%0d] got=%h want=%h", i, lane_data, exp_lane[i]);
         end
      end
      total++;
      if (underflow_count !== 8'd1) begin
         bad++; $display("FAIL uflow_count got=%0d want=1", underflow_count);
      end
      skip_slot = -1;
   endtask

   task automatic test_saturation();
      bit seen8;
      bit got_done;
      seen8 = 1'b0;
      got_done = 1'b0;
      do_reset();
      no_valid   = 1'b1;
      axis_valid = 1'b0;
      run = 1'b1;
      for (int n = 0; n < 2000 && ready_cnt < 302; n++) begin
         tick();
         if (ready_cnt == 9 && !seen8) begin
            seen8 = 1'b1;
            total++;
            if (underflow_count !== 8'd8) begin
               bad++; $display("FAIL sat_count_frame1 got=%0d want=8", underflow_count);
            end
         end
      end
      total++;
      if (ready_cnt < 302) begin
         bad++; $display("FAIL sat_slots got=%0d want=302", ready_cnt);
      end
      run = 1'b0;
      for (int n = 0; n < 100 && !got_done; n++) begin
         tick();
         if (frame_done === 1'b1) got_done = 1'b1;
      end
      total++;
      if (!got_done) begin
         bad++; $display("FAIL sat_done_timeout got=0 want=1");
      end
      total++;
      if (lane_data !== rep(EOF)) begin
         bad++; $display("FAIL sat_eof got=%h want=%h", lane_data, rep(EOF));
      end
      for (int i = 0; i < int'(VB) + 3; i++) begin
         tick();
         total++;
         if (lane_data !== rep(BLANK) || frame_active !== 1'b0) begin
            bad++; $display("FAIL sat_tail[%0d] got=%h/%b want=%h/0", i, lane_data,
                            frame_active, rep(BLANK));
         end
      end
      total++;
      if (underflow_count !== 8'd255) begin
         bad++; $display("FAIL sat_count got=%0d want=255", underflow_count);
      end
      total++;
      if (frame_count !== 8'd38) begin
         bad++; $display("FAIL sat_fcount got=%0d want=38", frame_count);
      end
      no_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      bit got_ready;
      got_ready = 1'b0;
      do_reset();
      skip_slot = 0;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int n = 0; n < 20 && !got_ready; n++) begin
         tick();
         if (axis_ready === 1'b1) got_ready = 1'b1;
      end
      total++;
      if (!got_ready) begin
         bad++; $display("FAIL rst_ready_timeout got=0 want=1");
      end
      tick();
      total++;
      if (underflow_count !== 8'd1) begin
         bad++; $display("FAIL rst_pre_ucount got=%0d want=1", underflow_count);
      end
      reset_sync = 1'b1;
      tick();
      reset_sync = 1'b0;
      total++;
      if (lane_data !== rep(BLANK)) begin
         bad++; $display("FAIL rst_lane got=%h want=%h", lane_data, rep(BLANK));
      end
      total++;
      if (axis_ready !== 1'b0 || frame_active !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL rst_flags got=%b%b%b want=000", axis_ready, frame_active,
                         frame_done);
      end
      total++;
      if (frame_count !== 8'd0 || underflow_count !== 8'd0) begin
         bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", frame_count, underflow_count);
      end
      tick();
      total++;
      if (lane_data !== rep(BLANK)) begin
         bad++; $display("FAIL rst_idle got=%h want=%h", lane_data, rep(BLANK));
      end
      skip_slot = -1;
      ready_cnt = 0;
      build_frame(beat_idx, 1'b0);
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (lane_data !== exp_lane[i]) begin
            bad++; $display("FAIL rst_sof[%0d] got=%h want=%h", i, lane_data, exp_lane[i]);
         end
      end
      total++;
      if (frame_count !== 8'd1) begin
         bad++; $display("FAIL rst_fcount got=%0d want=1", frame_count);
      end
      for (int i = 0; i < int'(FLEN); i++) tick();
   endtask

`ifdef HISPI_TX_TESTPAT_EN
   task automatic test_pattern_frame();
      do_reset();
      test_pattern = 1'b1;
      build_frame(beat_idx, 1'b1);
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < int'(FLEN); i++) begin
         tick();
         total++;
         if (lane_data !== exp_lane[i]) begin
            bad++; $display("FAIL tp_lane[%0d] got=%h want=%h", i, lane_data, exp_lane[i]);
         end
         total++;
         if (axis_ready !== 1'b0) begin
            bad++; $display("FAIL tp_ready[%0d] got=%b want=0", i, axis_ready);
         end
      end
      total++;
      if (underflow_count !== 8'd0) begin
         bad++; $display("FAIL tp_ucount got=%0d want=0", underflow_count);
      end
      test_pattern = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underflow();
      test_saturation();
      test_reset_mid_frame();
`ifdef HISPI_TX_TESTPAT_EN
      test_pattern_frame();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
